// File: rtl/tdc_controller_mc_if.sv
// Read-out handshake between the TDC controller (master) and its record consumer (slave).
interface tdc_controller_mc_if #(
    parameter int NCH = 4,
    parameter int TW  = 6
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           rdValid;
    logic           rdReady;
    logic [CHW-1:0] rdCh;
    logic [2:0]     rdToa;
    logic [TW-1:0]  rdTot;

    modport master (output rdValid, output rdCh, output rdToa, output rdTot, input rdReady);
    modport slave  (input rdValid, input rdCh, input rdToa, input rdTot, output rdReady);
endinterface

// File: rtl/tdc_controller_mc.sv
// Multi-channel TDC controller: per-channel leading-edge phase and pulse-width capture,
// round-robin read-out of finished measurements and a saturating lost-hit counter.
//
// state  | meaning
// IDLE   | waiting for an enabled leading edge inside the window
// TOT    | pulse still high, width counting
// PEND   | measurement done, waiting for read-out grant
module tdc_controller_mc #(
    parameter int NCH = 4,
    parameter int TW  = 6
) (
    input  logic                 clk320,
    input  logic                 reset,
    input  logic                 bcSync,
    input  logic [NCH-1:0]       enable,
    input  logic                 testMode,
    input  logic                 polaritySel,
    input  logic                 autoReset,
    input  logic [2:0]           winStart,
    input  logic [2:0]           winEnd,
    input  logic [NCH-1:0]       hit,
    tdc_controller_mc_if.master  rd,
    output logic [NCH-1:0]       busy,
    output logic [7:0]           lostCnt
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TW-1:0] TOT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TOT = 2'd1, S_PEND = 2'd2} ch_state_t;

    ch_state_t      state_q [NCH];
    ch_state_t      state_d [NCH];
    logic [2:0]     toa_q   [NCH];
    logic [2:0]     toa_d   [NCH];
    logic [TW-1:0]  tot_q   [NCH];
    logic [TW-1:0]  tot_d   [NCH];

    logic [2:0]     phase_q;
    logic [2:0]     test_off;
    logic           test_pulse;
    logic           in_win;
    logic           drop;
    logic           load;
    logic           any_pend;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] h_prev_q;
    logic [NCH-1:0] hit_rise;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] gnt;
    logic           found_hi;
    logic           found_lo;
    logic [CHW-1:0] idx_hi;
    logic [CHW-1:0] idx_lo;
    logic [CHW-1:0] gnt_idx;
    logic [2:0]     gnt_toa;
    logic [TW-1:0]  gnt_tot;
    logic [CHW-1:0] last_grant_q;
    logic [5:0]     loss_sum;
    logic [8:0]     lost_sum;
    logic [7:0]     lost_q;

    logic           rd_valid_q;
    logic [CHW-1:0] rd_ch_q;
    logic [2:0]     rd_toa_q;
    logic [TW-1:0]  rd_tot_q;

    // Internal test pulse covers three phases starting at winStart, wrapping mod 8.
    assign test_off   = phase_q - winStart;
    assign test_pulse = (test_off < 3'd3);
    assign lvl        = testMode ? {NCH{test_pulse}} : (hit ^ {NCH{polaritySel}});
    assign hit_rise   = lvl & ~h_prev_q;
    assign in_win     = (winStart <= phase_q) && (phase_q <= winEnd);
    assign drop       = autoReset && (phase_q == 3'd7);
    assign load       = !rd_valid_q || rd.rdReady;
    assign lost_sum   = {1'b0, lost_q} + {3'b000, loss_sum};

    always_ff @(posedge clk320) begin
        if (reset) begin
            phase_q  <= '0;
            h_prev_q <= '0;
            lost_q   <= '0;
        end else begin
            phase_q  <= bcSync ? 3'd0 : phase_q + 3'd1;
            h_prev_q <= lvl;
            lost_q   <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
        end
    end

    // Round-robin: lowest pending index above lastGrant wins, otherwise lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                if (CHW'(i) > last_grant_q) begin
                    found_hi = 1'b1;
                    idx_hi   = CHW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = CHW'(i);
                end
            end
        end
        any_pend = found_hi || found_lo;
        gnt_idx  = found_hi ? idx_hi : idx_lo;
        gnt      = '0;
        gnt_toa  = '0;
        gnt_tot  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CHW'(i) == gnt_idx) begin
                gnt[i]  = load && any_pend;
                gnt_toa = toa_q[i];
                gnt_tot = tot_q[i];
            end
        end
    end

    always_ff @(posedge clk320) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                toa_q[i]   <= '0;
                tot_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                toa_q[i]   <= toa_d[i];
                tot_q[i]   <= tot_d[i];
            end
        end
    end

    always_comb begin
        loss_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            toa_d[i]   = toa_q[i];
            tot_d[i]   = tot_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (hit_rise[i] && enable[i] && in_win) begin
                        state_d[i] = S_TOT;
                        toa_d[i]   = phase_q;
                        tot_d[i]   = TW'(1);
                    end
                end
                S_TOT: begin
                    if (hit_rise[i] && enable[i] && in_win) loss_sum = loss_sum + 6'd1;
                    if (lvl[i]) begin
                        if (tot_q[i] != TOT_MAX) tot_d[i] = tot_q[i] + TW'(1);
                    end else begin
                        state_d[i] = S_PEND;
                    end
                end
                S_PEND: begin
                    if (hit_rise[i] && enable[i] && in_win) loss_sum = loss_sum + 6'd1;
                    if (gnt[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (drop) begin
                        state_d[i] = S_IDLE;
                        loss_sum   = loss_sum + 6'd1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = '0;
        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] != S_IDLE);
            pend[i] = (state_q[i] == S_PEND);
        end
    end

    always_ff @(posedge clk320) begin
        if (reset) begin
            rd_valid_q   <= 1'b0;
            rd_ch_q      <= '0;
            rd_toa_q     <= '0;
            rd_tot_q     <= '0;
            last_grant_q <= CHW'(NCH - 1);
        end else if (load) begin
            if (any_pend) begin
                rd_valid_q   <= 1'b1;
                rd_ch_q      <= gnt_idx;
                rd_toa_q     <= gnt_toa;
                rd_tot_q     <= gnt_tot;
                last_grant_q <= gnt_idx;
            end else begin
                rd_valid_q   <= 1'b0;
            end
        end
    end

    assign rd.rdValid = rd_valid_q;
    assign rd.rdCh    = rd_ch_q;
    assign rd.rdToa   = rd_toa_q;
    assign rd.rdTot   = rd_tot_q;
    assign lostCnt    = lost_q;
endmodule
